// File: rtl/sa3_pkg.sv
// Shared types and sizing for the 3x3 systolic-array feeder:
// FSM state encoding, operand/result counts and operand byte-index helpers.
package sa3_pkg;

    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        SETUP = 3'd1,
        RUN   = 3'd2,
        WAIT  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    localparam int N_A   = 16;
    localparam int N_B   = 9;
    localparam int N_C   = 4;
    localparam int N_OPS = N_A + N_B;

    localparam int LD_W = $clog2((N_OPS - 1) + 1);
    localparam int DR_W = $clog2((N_C - 1) + 1);

    // Stream position of image byte i (row-major a11..a44).
    function automatic logic [LD_W-1:0] a_index(input int i);
        return LD_W'(i);
    endfunction

    // Stream position of kernel byte i; kernel bytes follow the image.
    function automatic logic [LD_W-1:0] b_index(input int i);
        return LD_W'(N_A + i);
    endfunction

endpackage

// File: rtl/sa3_feeder_if.sv
// Byte-stream handshakes of the feeder: operand bytes in, result bytes out.
// master = host/DMA side, slave = feeder side.
interface sa3_feeder_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/sa3_result_ser.sv
// Captures the four array results and streams them out as c11, c12, c21, c22
// with a valid/ready handshake; out_last marks the c22 byte.
module sa3_result_ser
    import sa3_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       capture,
    input  logic [7:0] c11,
    input  logic [7:0] c12,
    input  logic [7:0] c21,
    input  logic [7:0] c22,
    input  logic       drain,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       last_hs
);
    logic [7:0]       c_in [N_C];
    logic [N_C*8-1:0] res_vec;
    logic [DR_W-1:0]  dr_cnt_reg;
    logic             byte_hs;

    assign c_in[0] = c11;
    assign c_in[1] = c12;
    assign c_in[2] = c21;
    assign c_in[3] = c22;

    genvar gi;
    generate
        for (gi = 0; gi < N_C; gi++) begin : g_res
            logic [7:0] res_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    res_reg <= '0;
                else if (capture)
                    res_reg <= c_in[gi];
            end
            assign res_vec[gi*8 +: 8] = res_reg;
        end
    endgenerate

    assign byte_hs = drain && out_ready;
    assign last_hs = byte_hs && (dr_cnt_reg == DR_W'(N_C - 1));

    // The byte index only moves on a handshake, so data is held during stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            dr_cnt_reg <= '0;
        else if (last_hs)
            dr_cnt_reg <= '0;
        else if (byte_hs)
            dr_cnt_reg <= dr_cnt_reg + 1'b1;
    end

    assign out_valid = drain;
    assign out_data  = res_vec[{dr_cnt_reg, 3'b000} +: 8];
    assign out_last  = drain && (dr_cnt_reg == DR_W'(N_C - 1));

endmodule

// File: rtl/sa3_feeder.sv
// Sequencer for the 3x3 systolic array: loads 25 operand bytes, holds them as
// parallel operands, runs the activation window and unloads the 2x2 result.
module sa3_feeder
    import sa3_pkg::*;
#(
    parameter int SETUP_CYCLES  = 3,
    parameter int ACTIVE_CYCLES = 17,
    parameter int DONE_TIMEOUT  = 64
) (
    input  logic             clk,
    input  logic             rst,
    sa3_feeder_if.slave      bus,
    output logic [N_A*8-1:0] a_mat,
    output logic [N_B*8-1:0] b_mat,
    output logic             active_sa3,
    input  logic             done_sa3,
    input  logic [7:0]       c11,
    input  logic [7:0]       c12,
    input  logic [7:0]       c21,
    input  logic [7:0]       c22,
    output logic             busy,
    output logic             err
);
    localparam int MAX_SA  = (SETUP_CYCLES > ACTIVE_CYCLES) ? SETUP_CYCLES : ACTIVE_CYCLES;
    localparam int CNT_MAX = (MAX_SA > DONE_TIMEOUT) ? MAX_SA : DONE_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t            state_reg, state_next;
    logic [LD_W-1:0]   ld_cnt_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  phase_last;
    logic              done_seen_reg;
    logic              err_reg;
    logic              in_ready_w, drain_w;
    logic              load_hs, ld_last, phase_end, capture, timeout, last_hs;

    assign load_hs = in_ready_w && bus.in_valid;
    assign ld_last = (ld_cnt_reg == LD_W'(N_OPS - 1));

    always_comb begin
        phase_last = '0;
        case (state_reg)
            SETUP:   phase_last = CNT_W'(SETUP_CYCLES - 1);
            RUN:     phase_last = CNT_W'(ACTIVE_CYCLES - 1);
            WAIT:    phase_last = CNT_W'(DONE_TIMEOUT - 1);
            default: phase_last = '0;
        endcase
    end
    assign phase_end = (cnt_reg == phase_last);

    // Only the first done sample of a job latches; a timeout latches whatever is on c.
    assign capture = ((state_reg == RUN) && done_sa3 && !done_seen_reg)
                   || ((state_reg == WAIT) && (done_sa3 || phase_end));
    assign timeout = (state_reg == WAIT) && phase_end && !done_sa3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_reg <= LOAD;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LOAD:    if (load_hs && ld_last) state_next = SETUP;
            SETUP:   if (phase_end) state_next = RUN;
            RUN:     if (phase_end) state_next = (done_seen_reg || done_sa3) ? DRAIN : WAIT;
            WAIT:    if (done_sa3 || phase_end) state_next = DRAIN;
            DRAIN:   if (last_hs) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    always_comb begin
        in_ready_w = 1'b0;
        active_sa3 = 1'b0;
        drain_w    = 1'b0;
        busy       = 1'b1;
        case (state_reg)
            LOAD: begin
                in_ready_w = 1'b1;
                busy       = (ld_cnt_reg != '0);
            end
            RUN:     active_sa3 = 1'b1;
            DRAIN:   drain_w    = 1'b1;
            default: ;
        endcase
    end

    assign bus.in_ready = in_ready_w;
    assign err          = err_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_reg <= '0;
        else if (state_next != state_reg || state_reg == LOAD || state_reg == DRAIN)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_reg + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_cnt_reg    <= '0;
            done_seen_reg <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            if (load_hs)
                ld_cnt_reg <= ld_last ? '0 : ld_cnt_reg + 1'b1;
            if (state_reg == DRAIN)
                done_seen_reg <= 1'b0;
            else if (capture)
                done_seen_reg <= 1'b1;
            if (timeout)
                err_reg <= 1'b1;
        end
    end

    // Operand bytes are written only on their own LOAD handshake and hold otherwise.
    genvar gi;
    generate
        for (gi = 0; gi < N_A; gi++) begin : g_a
            logic [7:0] byte_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    byte_reg <= '0;
                else if (load_hs && ld_cnt_reg == a_index(gi))
                    byte_reg <= bus.in_data;
            end
            assign a_mat[gi*8 +: 8] = byte_reg;
        end
        for (gi = 0; gi < N_B; gi++) begin : g_b
            logic [7:0] byte_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    byte_reg <= '0;
                else if (load_hs && ld_cnt_reg == b_index(gi))
                    byte_reg <= bus.in_data;
            end
            assign b_mat[gi*8 +: 8] = byte_reg;
        end
    endgenerate

    sa3_result_ser u_ser (
        .clk       (clk),
        .rst       (rst),
        .capture   (capture),
        .c11       (c11),
        .c12       (c12),
        .c21       (c21),
        .c22       (c22),
        .drain     (drain_w),
        .out_ready (bus.out_ready),
        .out_valid (bus.out_valid),
        .out_data  (bus.out_data),
        .out_last  (bus.out_last),
        .last_hs   (last_hs)
    );

endmodule

// File: tb/tb_sa3_feeder.sv
// Self-checking bench for sa3_feeder with a stub 3x3 array that pulses done
// one cycle after active_sa3 falls (or early / never, per job).
module tb_sa3_feeder;
    localparam int SETUP_CYCLES  = 3;
    localparam int ACTIVE_CYCLES = 17;
    localparam int DONE_TIMEOUT  = 64;

    localparam int MODE_NONE   = 0;
    localparam int MODE_NORMAL = 1;
    localparam int MODE_EARLY  = 2;

    logic         clk;
    logic         rst;
    logic [127:0] a_mat;
    logic [71:0]  b_mat;
    logic         active_sa3;
    logic         done_sa3;
    logic [7:0]   c_val [4];
    logic         busy;
    logic         err;

    logic         stub_done;
    logic         man_done;
    logic         act_d;
    int           run_n;
    int           stub_mode;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    bit           err_model = 1'b0;
    int           job_no = 0;

    sa3_feeder_if bus ();

    sa3_feeder #(
        .SETUP_CYCLES  (SETUP_CYCLES),
        .ACTIVE_CYCLES (ACTIVE_CYCLES),
        .DONE_TIMEOUT  (DONE_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .a_mat      (a_mat),
        .b_mat      (b_mat),
        .active_sa3 (active_sa3),
        .done_sa3   (done_sa3),
        .c11        (c_val[0]),
        .c12        (c_val[1]),
        .c21        (c_val[2]),
        .c22        (c_val[3]),
        .busy       (busy),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Stub array: normal = one-cycle done one cycle after active falls;
    // early = done seen by the feeder on RUN edge 10; none = never.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_d     <= 1'b0;
            run_n     <= 0;
            stub_done <= 1'b0;
        end else begin
            act_d     <= active_sa3;
            run_n     <= active_sa3 ? run_n + 1 : 0;
            stub_done <= (stub_mode == MODE_NORMAL && act_d && !active_sa3)
                      || (stub_mode == MODE_EARLY && active_sa3 && run_n == 8);
        end
    end

    assign done_sa3 = stub_done | man_done;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic make_bytes(input bit nominal, output logic [7:0] bytes [25]);
        for (int i = 0; i < 25; i++)
            bytes[i] = nominal ? 8'((i < 16) ? i + 1 : i - 15) : 8'($urandom_range(255));
    endtask

    // Streams 25 bytes with optional in_valid bubbles; k = cycle of the last accept.
    task automatic load_bytes(input logic [7:0] bytes [25], input int bubble_pct, output int k);
        int  idx;
        int  guard;
        bit  rdy;
        idx   = 0;
        guard = 0;
        k     = -1;
        while (idx < 25 && guard < 600) begin
            bus.in_valid = ($urandom_range(99) >= bubble_pct);
            bus.in_data  = bytes[idx];
            rdy = bus.in_ready;
            @(posedge clk); #1;
            if (bus.in_valid && rdy) begin
                idx++;
                k = cyc;
            end
            guard++;
        end
        bus.in_valid = 1'b0;
        check("load_count", 128'(idx), 128'(25));
    endtask

    task automatic do_job(input int bubble_pct, input int stall, input int mode,
                          input bit inject, input bit nominal);
        logic [7:0]   bytes [25];
        logic [127:0] exp_a;
        logic [71:0]  exp_b;
        logic [7:0]   exp_c [4];
        int k, guard, first_act, last_act, act_cnt, ov_cyc, leaks, bad, wait_exp;
        logic [7:0] d0;
        logic       l0;

        make_bytes(nominal, bytes);
        for (int i = 0; i < 16; i++) exp_a[i*8 +: 8] = bytes[i];
        for (int i = 0; i < 9; i++)  exp_b[i*8 +: 8] = bytes[16 + i];
        if (nominal) c_val = '{8'd192, 8'd237, 8'd116, 8'd161};
        else for (int i = 0; i < 4; i++) c_val[i] = 8'($urandom_range(255));
        exp_c     = c_val;
        stub_mode = mode;

        load_bytes(bytes, bubble_pct, k);
        check("a_mat", a_mat, exp_a);
        check("b_mat", 128'(b_mat), 128'(exp_b));
        check("busy_setup", 128'(busy), 128'(1));
        check("err_pre", 128'(err), 128'(err_model));
        if (nominal) begin
            check("a11", 128'(a_mat[7:0]), 128'(1));
            check("a44", 128'(a_mat[127:120]), 128'(16));
            check("b33", 128'(b_mat[71:64]), 128'(9));
        end

        first_act = -1; last_act = -1; act_cnt = 0; leaks = 0; guard = 0;
        while (!bus.out_valid && guard < 400) begin
            bus.in_valid = 1'($urandom_range(1));
            bus.in_data  = 8'($urandom_range(255));
            if (bus.in_ready) leaks++;
            @(posedge clk); #1;
            if (active_sa3) begin
                if (first_act < 0) first_act = cyc;
                last_act = cyc;
                act_cnt++;
            end
            guard++;
        end
        bus.in_valid = 1'b0;
        ov_cyc = cyc;

        wait_exp = (mode == MODE_EARLY)  ? 1 :
                   (mode == MODE_NORMAL) ? 3 : 1 + DONE_TIMEOUT;
        if (mode == MODE_NONE) err_model = 1'b1;
        check("setup_len", 128'(first_act - k), 128'(SETUP_CYCLES));
        check("active_len", 128'(act_cnt), 128'(ACTIVE_CYCLES));
        check("ov_delay", 128'(ov_cyc - last_act), 128'(wait_exp));
        check("in_ready_leak", 128'(leaks), 128'(0));
        check("err", 128'(err), 128'(err_model));

        if (inject) begin
            for (int i = 0; i < 4; i++) c_val[i] = ~exp_c[i];
            man_done      = 1'b1;
            bus.out_ready = 1'b0;
            @(posedge clk); #1;
            man_done = 1'b0;
        end

        bad = 0;
        for (int b = 0; b < 4; b++) begin
            bus.out_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                d0 = bus.out_data;
                l0 = bus.out_last;
                @(posedge clk); #1;
                if (!bus.out_valid || bus.out_data !== d0 || bus.out_last !== l0 || bus.in_ready) bad++;
            end
            check($sformatf("out_data%0d", b), 128'(bus.out_data), 128'(exp_c[b]));
            check($sformatf("out_last%0d", b), 128'({bus.out_valid, bus.out_last}),
                  128'({1'b1, (b == 3)}));
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            if (b < 3 && (bus.in_ready || !bus.out_valid)) bad++;
        end
        bus.out_ready = 1'b0;
        check("drain_hold", 128'(bad), 128'(0));
        check("load_reentry", 128'({bus.out_valid, bus.in_ready, busy}), 128'(3'b010));
        check("a_mat_hold", a_mat, exp_a);
        check("b_mat_hold", 128'(b_mat), 128'(exp_b));
        job_no++;
        $display("job %0d: mode=%0d bubbles=%0d stall=%0d result=%h %h %h %h err=%0d",
                 job_no, mode, bubble_pct, stall, exp_c[0], exp_c[1], exp_c[2], exp_c[3], err);
    endtask

    initial begin
        logic [7:0] bytes [25];
        int k, guard, act_cnt;

        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        man_done      = 1'b0;
        stub_mode     = MODE_NORMAL;
        c_val         = '{8'd0, 8'd0, 8'd0, 8'd0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        check("rst_ctrl", 128'({bus.in_ready, busy, bus.out_valid, active_sa3, bus.out_last, err}),
              128'(6'b100000));
        check("rst_out_data", 128'(bus.out_data), 128'(0));
        check("rst_a_mat", a_mat, 128'(0));
        check("rst_b_mat", 128'(b_mat), 128'(0));

        do_job(0, 0, MODE_NORMAL, 1'b0, 1'b1);
        do_job(40, 0, MODE_NORMAL, 1'b0, 1'b0);
        do_job(20, 5, MODE_NORMAL, 1'b0, 1'b0);
        do_job(0, 2, MODE_EARLY, 1'b1, 1'b0);
        do_job(0, 0, MODE_NONE, 1'b0, 1'b0);
        do_job(30, 1, MODE_NORMAL, 1'b0, 1'b0);

        // Reset asserted between clock edges in the 8th RUN cycle.
        stub_mode = MODE_NORMAL;
        make_bytes(1'b0, bytes);
        load_bytes(bytes, 0, k);
        act_cnt = 0;
        guard   = 0;
        while (act_cnt < 8 && guard < 100) begin
            @(posedge clk); #1;
            if (active_sa3) act_cnt++;
            guard++;
        end
        check("run8_reached", 128'(act_cnt), 128'(8));
        #2 rst = 1'b0;
        #1;
        check("async_active", 128'({active_sa3, bus.out_valid}), 128'(2'b00));
        check("async_ctrl", 128'({bus.in_ready, busy, err}), 128'(3'b100));
        check("async_a_mat", a_mat, 128'(0));
        check("async_b_mat", 128'(b_mat), 128'(0));
        err_model = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        do_job(0, 0, MODE_NORMAL, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
